// File: rtl/intc_pkg.sv
// intc_pkg: shared constants for the interrupt controller block.
//   - register address map within the 8-byte I/O window
//   - bit position of the "valid" flag in the VECT read value
//   - maximum number of supported interrupt sources
package intc_pkg;

  localparam logic [2:0] INTC_PEND = 3'd0;
  localparam logic [2:0] INTC_MASK = 3'd1;
  localparam logic [2:0] INTC_MODE = 3'd2;
  localparam logic [2:0] INTC_VECT = 3'd3;
  localparam logic [2:0] INTC_ISR  = 3'd4;
  localparam logic [2:0] INTC_EOI  = 3'd5;

  localparam int INTC_VECT_VALID_BIT = 7;
  localparam int INTC_MAX_SRC        = 8;

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: fixed-priority encoder, lowest set index wins.
// Ports:
//   req   in  NSRC  request vector
//   valid out 1     at least one request bit set
//   idx   out 3     index of the lowest set request bit (0 when none)
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] req,
  output logic            valid,
  output logic [2:0]      idx
);

  // Scan from the top down so the last hit (lowest index) is what remains.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: prioritized interrupt controller on the 8-bit peripheral bus.
// Latches edge/level requests into PEND, masks them with MASK, and drives
// one registered INTR to the CPU. The CPU acknowledges by reading VECT and
// retires the in-service source by writing EOI.
// Ports:
//   CLK      in   1     system clock
//   RESET    in   1     synchronous, active-high reset
//   AD       in   3     register address (PEND,MASK,MODE,VECT,ISR,EOI)
//   DI       in   8     write data
//   DO       out  8     read data, combinational from AD
//   RW       in   1     1 = read, 0 = write
//   CS       in   1     block select; side effects once per CS assertion
//   IRQ_SRC  in   NSRC  raw interrupt requests, synchronous to CLK
//   INTR     out  1     registered interrupt request
// Build option: define INTC_NESTING_EN to let a higher-priority source
// preempt a lower-priority one already in service.
module intr_ctrl
  import intc_pkg::*;
#(
  parameter int         NSRC     = 4,
  parameter logic [7:0] RST_MODE = 8'h00
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [2:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic            RW,
  input  logic            CS,
  input  logic [NSRC-1:0] IRQ_SRC,
  output logic            INTR
);

  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] isr_q,  isr_d;
  logic [NSRC-1:0] src_q,  src_d;
  logic            intr_q, intr_d;
  logic            cs_q,   cs_d;

  logic            acc, wr_acc, rd_acc, ack, eoi, eligible;
  logic            win_vld, isr_vld;
  logic [2:0]      win_idx, isr_idx;
  logic [NSRC-1:0] win_oh, isr_oh, w1c, edge_set;
  logic [7:0]      pend8, mask8, mode8, isr8;
  logic            unused_di;

  assign unused_di = &{1'b0, DI};

  intc_prio_enc #(.NSRC(NSRC)) u_win_enc (
    .req   (pend_q & mask_q),
    .valid (win_vld),
    .idx   (win_idx)
  );

  intc_prio_enc #(.NSRC(NSRC)) u_isr_enc (
    .req   (isr_q),
    .valid (isr_vld),
    .idx   (isr_idx)
  );

  // Without nesting any in-service source blocks new requests; with nesting
  // only an in-service source of equal or higher priority blocks the winner.
  always_comb begin
`ifdef INTC_NESTING_EN
    eligible = win_vld & (~isr_vld | (isr_idx > win_idx));
`else
    eligible = win_vld & ~isr_vld;
`endif
  end

  always_comb begin
    // Rising edge of CS marks the single cycle an access takes effect.
    acc    = CS & ~cs_q;
    wr_acc = acc & ~RW;
    rd_acc = acc & RW;
    ack    = rd_acc & (AD == INTC_VECT) & eligible;
    eoi    = wr_acc & (AD == INTC_EOI) & isr_vld;

    for (int i = 0; i < NSRC; i++) begin
      win_oh[i] = (3'(i) == win_idx);
      isr_oh[i] = (3'(i) == isr_idx);
    end

    w1c      = (wr_acc && AD == INTC_PEND) ? DI[NSRC-1:0] : '0;
    edge_set = IRQ_SRC & ~src_q;

    // Edge bits: clears first, then a new edge re-pends in the same cycle.
    // Level bits simply track the request line.
    for (int i = 0; i < NSRC; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = (pend_q[i] & ~w1c[i] & ~(ack & win_oh[i])) | edge_set[i];
      end else begin
        pend_d[i] = IRQ_SRC[i];
      end
    end

    mask_d = (wr_acc && AD == INTC_MASK) ? DI[NSRC-1:0] : mask_q;
    mode_d = (wr_acc && AD == INTC_MODE) ? DI[NSRC-1:0] : mode_q;

    isr_d = isr_q;
    if (ack) isr_d = isr_d | win_oh;
    if (eoi) isr_d = isr_d & ~isr_oh;

    intr_d = eligible;
    src_d  = IRQ_SRC;
    cs_d   = CS;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= RST_MODE[NSRC-1:0];
      isr_q  <= '0;
      src_q  <= '0;
      intr_q <= 1'b0;
      cs_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      isr_q  <= isr_d;
      src_q  <= src_d;
      intr_q <= intr_d;
      cs_q   <= cs_d;
    end
  end

  assign INTR = intr_q;

  // Register readback, zero-extended to the bus width.
  always_comb begin
    pend8 = '0;
    mask8 = '0;
    mode8 = '0;
    isr8  = '0;
    pend8[NSRC-1:0] = pend_q;
    mask8[NSRC-1:0] = mask_q;
    mode8[NSRC-1:0] = mode_q;
    isr8[NSRC-1:0]  = isr_q;
    DO = 8'h00;
    case (AD)
      INTC_PEND: DO = pend8;
      INTC_MASK: DO = mask8;
      INTC_MODE: DO = mode8;
      INTC_VECT: begin
        if (eligible) begin
          DO[INTC_VECT_VALID_BIT] = 1'b1;
          DO[2:0]                 = win_idx;
        end
      end
      INTC_ISR:  DO = isr8;
      default:   DO = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

  localparam int         NSRC     = 4;
  localparam logic [7:0] RST_MODE = 8'h00;
  localparam logic [7:0] SRCMSK   = 8'h0F;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic [2:0]      AD = '0;
  logic [7:0]      DI = '0;
  logic [7:0]      DO;
  logic            RW = 1'b0;
  logic            CS = 1'b0;
  logic [NSRC-1:0] IRQ_SRC = '0;
  logic            INTR;

  intr_ctrl #(.NSRC(NSRC), .RST_MODE(RST_MODE)) dut (
    .CLK(CLK), .RESET(RESET), .AD(AD), .DI(DI), .DO(DO), .RW(RW),
    .CS(CS), .IRQ_SRC(IRQ_SRC), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  bit chk_rd = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];

  // Reference model: register contents as plain bit vectors.
  bit [7:0] m_pend, m_mask, m_mode, m_isr, m_src;
  bit       m_intr, m_cs;

  function automatic int m_winner();
    for (int i = 0; i < NSRC; i++) if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic int m_isr_low();
    for (int i = 0; i < NSRC; i++) if (m_isr[i]) return i;
    return -1;
  endfunction

  function automatic bit m_elig();
    int w;
    w = m_winner();
    if (w < 0) return 1'b0;
`ifdef INTC_NESTING_EN
    return (m_isr_low() < 0) || (m_isr_low() > w);
`else
    return m_isr == 8'h00;
`endif
  endfunction

  function automatic logic [7:0] m_do(input logic [2:0] ad);
    case (ad)
      3'd0: return m_pend;
      3'd1: return m_mask;
      3'd2: return m_mode;
      3'd3: return m_elig() ? (8'h80 | 8'(m_winner())) : 8'h00;
      3'd4: return m_isr;
      default: return 8'h00;
    endcase
  endfunction

  bit       mm_acc, mm_el;
  int       mm_w, mm_l;
  bit [7:0] mm_irq, mm_next;

  always @(posedge CLK) begin
    if (RESET) begin
      m_pend = 0; m_mask = 0; m_mode = RST_MODE & SRCMSK; m_isr = 0;
      m_src = 0; m_intr = 0; m_cs = 0;
    end else begin
      mm_acc = CS && !m_cs;
      mm_w   = m_winner();
      mm_el  = m_elig();
      mm_l   = m_isr_low();
      mm_irq = 8'(IRQ_SRC);
      mm_next = 0;
      for (int i = 0; i < NSRC; i++) begin
        if (m_mode[i]) begin
          mm_next[i] = m_pend[i];
          if (mm_acc && !RW && AD == 3'd0 && DI[i]) mm_next[i] = 0;
          if (mm_acc && RW && AD == 3'd3 && mm_el && i == mm_w) mm_next[i] = 0;
          if (!m_src[i] && mm_irq[i]) mm_next[i] = 1;
        end else begin
          mm_next[i] = mm_irq[i];
        end
      end
      if (mm_acc && RW && AD == 3'd3 && mm_el) m_isr[mm_w] = 1'b1;
      if (mm_acc && !RW && AD == 3'd5 && mm_l >= 0) m_isr[mm_l] = 1'b0;
      if (mm_acc && !RW && AD == 3'd1) m_mask = DI & SRCMSK;
      if (mm_acc && !RW && AD == 3'd2) m_mode = DI & SRCMSK;
      m_pend = mm_next;
      m_intr = mm_el;
      m_src  = mm_irq;
      m_cs   = CS;
    end
  end

  // Monitor: pops the expected read value whenever a checked read is on the bus.
  always @(negedge CLK) begin
    #2;
    if (mon_en) begin
      checks++;
      if (INTR !== m_intr) begin
        errors++;
        $display("FAIL intr t=%0t got=%b exp=%b", $time, INTR, m_intr);
      end
      if (chk_rd) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty t=%0t got=%h", $time, DO);
        end else begin
          logic [7:0] e;
          string n;
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (DO !== e) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", n, $time, DO, e);
          end
        end
      end
    end
  end

  // chk: 0 = no check, 1 = constant expectation, 2 = model expectation
  task automatic drv(input bit cs, input bit rw, input logic [2:0] ad,
                     input logic [7:0] di, input bit rst,
                     input logic [NSRC-1:0] irq, input int chk,
                     input logic [7:0] exp, input string nm);
    @(negedge CLK);
    RESET = rst; CS = cs; RW = rw; AD = ad; DI = di; IRQ_SRC = irq;
    chk_rd = (chk != 0);
    if (chk == 1) begin exp_q.push_back(exp); name_q.push_back(nm); end
    if (chk == 2) begin exp_q.push_back(m_do(ad)); name_q.push_back(nm); end
  endtask

  task automatic idle(input int n, input logic [NSRC-1:0] irq);
    for (int i = 0; i < n; i++) drv(0, 0, 3'd0, 8'h00, 0, irq, 0, 8'h00, "");
  endtask

  task automatic wr(input logic [2:0] ad, input logic [7:0] di, input logic [NSRC-1:0] irq);
    drv(1, 0, ad, di, 0, irq, 0, 8'h00, "");
    idle(1, irq);
  endtask

  task automatic rd(input logic [2:0] ad, input logic [7:0] exp,
                    input logic [NSRC-1:0] irq, input string nm);
    drv(1, 1, ad, 8'h00, 0, irq, 1, exp, nm);
    idle(1, irq);
  endtask

  task automatic do_reset();
    drv(0, 0, 3'd0, 8'h00, 1, '0, 0, 8'h00, "");
    idle(1, '0);
  endtask

  logic [NSRC-1:0] rnd_irq;

  initial begin
    drv(0, 0, 3'd0, 8'h00, 1, '0, 0, 8'h00, "");
    drv(0, 0, 3'd0, 8'h00, 1, '0, 0, 8'h00, "");
    mon_en = 1;
    idle(1, '0);
    rd(3'd0, 8'h00, '0, "reset_pend");
    rd(3'd1, 8'h00, '0, "reset_mask");
    rd(3'd2, RST_MODE & SRCMSK, '0, "reset_mode");
    rd(3'd4, 8'h00, '0, "reset_isr");
    rd(3'd6, 8'h00, '0, "addr6");

    // Edge source basic flow
    wr(3'd1, 8'h03, '0);
    wr(3'd2, 8'h0F, '0);
    idle(1, 4'b0010);
    rd(3'd0, 8'h02, '0, "edge_pend");
    rd(3'd3, 8'h81, '0, "edge_vect");
    rd(3'd4, 8'h02, '0, "edge_isr");
    rd(3'd0, 8'h00, '0, "edge_pend_clr");
    wr(3'd5, 8'hA5, '0);
    rd(3'd4, 8'h00, '0, "edge_eoi");

    // Level source
    do_reset();
    wr(3'd2, 8'h0E, '0);
    wr(3'd1, 8'h01, '0);
    idle(2, 4'b0001);
    rd(3'd3, 8'h80, 4'b0001, "level_vect");
    rd(3'd4, 8'h01, 4'b0001, "level_isr");
    wr(3'd5, 8'h00, 4'b0001);
    idle(3, 4'b0001);
    rd(3'd3, 8'h80, 4'b0001, "level_vect2");
    wr(3'd5, 8'h00, 4'b0001);
    idle(2, '0);
    rd(3'd0, 8'h00, '0, "level_drop");

    // Priority between simultaneous edges
    do_reset();
    wr(3'd2, 8'h0F, '0);
    wr(3'd1, 8'h0F, '0);
    idle(1, 4'b0101);
    idle(2, '0);
    rd(3'd3, 8'h80, '0, "prio_vect0");
    wr(3'd5, 8'h00, '0);
    idle(1, '0);
    rd(3'd3, 8'h82, '0, "prio_vect2");
    wr(3'd5, 8'h00, '0);
    rd(3'd4, 8'h00, '0, "prio_isr");

    // Preemption behaviour
    do_reset();
    wr(3'd2, 8'h0F, '0);
    wr(3'd1, 8'h0F, '0);
    idle(1, 4'b0100);
    idle(2, '0);
    rd(3'd3, 8'h82, '0, "nest_vect2");
    rd(3'd4, 8'h04, '0, "nest_isr2");
    idle(1, 4'b0001);
    idle(2, '0);
`ifdef INTC_NESTING_EN
    rd(3'd3, 8'h80, '0, "nest_vect0");
    rd(3'd4, 8'h05, '0, "nest_isr5");
    wr(3'd5, 8'h00, '0);
    rd(3'd4, 8'h04, '0, "nest_eoi1");
    wr(3'd5, 8'h00, '0);
    rd(3'd4, 8'h00, '0, "nest_eoi2");
`else
    rd(3'd3, 8'h00, '0, "nonest_vect");
    rd(3'd4, 8'h04, '0, "nonest_isr");
    wr(3'd5, 8'h00, '0);
    idle(1, '0);
    rd(3'd3, 8'h80, '0, "nonest_vect0");
    rd(3'd4, 8'h01, '0, "nonest_isr0");
    wr(3'd5, 8'h00, '0);
    rd(3'd4, 8'h00, '0, "nonest_eoi");
`endif

    // Spurious read, W1C vs edge, held CS, mask clear
    do_reset();
    rd(3'd3, 8'h00, '0, "spur_vect");
    rd(3'd4, 8'h00, '0, "spur_isr");
    wr(3'd2, 8'h0F, '0);
    wr(3'd1, 8'h0F, '0);
    drv(1, 0, 3'd0, 8'h02, 0, 4'b0010, 0, 8'h00, "");
    idle(1, '0);
    rd(3'd0, 8'h02, '0, "w1c_vs_edge");
    wr(3'd0, 8'h02, '0);
    rd(3'd0, 8'h00, '0, "w1c_clear");
    idle(1, 4'b0010);
    idle(1, '0);
    drv(1, 1, 3'd3, 8'h00, 0, '0, 1, 8'h81, "held_vect0");
    for (int i = 1; i < 4; i++) drv(1, 1, 3'd3, 8'h00, 0, '0, 1, 8'h00, "held_vect_n");
    idle(1, '0);
    rd(3'd4, 8'h02, '0, "held_isr");
    rd(3'd0, 8'h00, '0, "held_pend");
    wr(3'd5, 8'h00, '0);
    rd(3'd4, 8'h00, '0, "held_eoi");
    idle(1, 4'b0001);
    idle(2, '0);
    wr(3'd1, 8'h00, '0);
    idle(2, '0);
    rd(3'd0, 8'h01, '0, "mask_retain");

    // Reset mid-service
    do_reset();
    wr(3'd2, 8'h0E, '0);
    wr(3'd1, 8'h01, '0);
    idle(2, 4'b0001);
    drv(1, 1, 3'd3, 8'h00, 0, 4'b0001, 1, 8'h80, "rst_vect");
    drv(0, 0, 3'd0, 8'h00, 1, 4'b0001, 0, 8'h00, "");
    idle(1, '0);
    rd(3'd0, 8'h00, '0, "rst_pend");
    rd(3'd1, 8'h00, '0, "rst_mask");
    rd(3'd2, RST_MODE & SRCMSK, '0, "rst_mode");
    rd(3'd4, 8'h00, '0, "rst_isr");

    // Randomized traffic against the model
    rnd_irq = '0;
    for (int it = 0; it < 1500; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) == 0) rnd_irq = rnd_irq ^ NSRC'($urandom);
      if (r < 2) begin
        drv(0, 0, 3'd0, 8'h00, 1, rnd_irq, 0, 8'h00, "");
      end else if (r < 40) begin
        idle(1, rnd_irq);
      end else begin
        logic [2:0] ad;
        logic [7:0] di;
        bit rw;
        int len;
        ad  = 3'($urandom_range(0, 7));
        di  = 8'($urandom);
        rw  = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++)
          drv(1, rw, ad, di, 0, rnd_irq, rw ? 2 : 0, 8'h00, "rand_read");
        idle(1, rnd_irq);
      end
    end
    idle(2, '0);
    mon_en = 0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
